// File: rtl/alu_serial_if.sv
// Handshake and operand/result bundle between the control FSM and the digit-serial ALU.
interface alu_serial_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [7:0]       command;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carryout;
   logic             overflow;
   logic             zero;
   logic             cmd_err;

   modport master (
      output start, a, b, command,
      input  busy, done, result, carryout, overflow, zero, cmd_err
   );

   modport slave (
      input  start, a, b, command,
      output busy, done, result, carryout, overflow, zero, cmd_err
   );
endinterface

// File: rtl/alu_serial.sv
// Digit-serial ALU: eight one-hot ops on WIDTH-bit operands, DIGIT bits per clock, LSB first.
// state | meaning
// IDLE  | waiting for start
// RUN   | one digit per clock, N clocks
// DONE  | one-cycle done pulse, start here chains the next op
module alu_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   alu_serial_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [7:0] OP_ADD  = 8'h01;
   localparam logic [7:0] OP_SUB  = 8'h02;
   localparam logic [7:0] OP_XOR  = 8'h04;
   localparam logic [7:0] OP_SLT  = 8'h08;
   localparam logic [7:0] OP_AND  = 8'h10;
   localparam logic [7:0] OP_NAND = 8'h20;
   localparam logic [7:0] OP_NOR  = 8'h40;
   localparam logic [7:0] OP_OR   = 8'h80;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic             accept, last;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [7:0]       cmd;
   logic [WIDTH-1:0] opa, opb, acc;
   logic [WIDTH-1:0] result_q;
   logic             carryout_q, overflow_q, zero_q, cmd_err_q;

   logic             is_add, is_sub, is_slt, arith, valid, sub_like_in;
   logic [DIGIT-1:0] da, db, dres;
   logic [DIGIT:0]   dsum;
   logic             dov;
   logic [WIDTH+DIGIT-1:0] acc_cat;
   logic [WIDTH-1:0] acc_nxt, res_fin;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: if (bus.start) begin
            accept    = 1'b1;
            state_nxt = RUN;
         end
         RUN:  if (last) state_nxt = DONE;
         DONE: if (bus.start) begin
            accept    = 1'b1;
            state_nxt = RUN;
         end else begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign last     = (cnt == LAST);
   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);

   assign is_add      = (cmd == OP_ADD);
   assign is_sub      = (cmd == OP_SUB);
   assign is_slt      = (cmd == OP_SLT);
   assign arith       = is_add | is_sub | is_slt;
   assign valid       = arith | (cmd == OP_XOR) | (cmd == OP_AND) | (cmd == OP_NAND)
                        | (cmd == OP_NOR) | (cmd == OP_OR);
   assign sub_like_in = (bus.command == OP_SUB) | (bus.command == OP_SLT);

   // Operands shift right each digit, so the active digit is always the low slice.
   always_comb begin
      da   = opa[DIGIT-1:0];
      db   = opb[DIGIT-1:0];
      dsum = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, carry};
      dov  = (da[DIGIT-1] == db[DIGIT-1]) && (dsum[DIGIT-1] != da[DIGIT-1]);
      case (cmd)
         OP_ADD, OP_SUB, OP_SLT: dres = dsum[DIGIT-1:0];
         OP_XOR:  dres = da ^ db;
         OP_AND:  dres = da & db;
         OP_NAND: dres = ~(da & db);
         OP_NOR:  dres = ~(da | db);
         OP_OR:   dres = da | db;
         default: dres = '0;
      endcase
      acc_cat = {dres, acc} >> DIGIT;
      acc_nxt = acc_cat[WIDTH-1:0];
      res_fin = is_slt ? {{(WIDTH-1){1'b0}}, dsum[DIGIT-1] ^ dov} : acc_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         carry      <= 1'b0;
         cmd        <= '0;
         opa        <= '0;
         opb        <= '0;
         acc        <= '0;
         result_q   <= '0;
         carryout_q <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b1;
         cmd_err_q  <= 1'b0;
      end else if (accept) begin
         cnt   <= '0;
         carry <= sub_like_in;
         cmd   <= bus.command;
         opa   <= bus.a;
         opb   <= sub_like_in ? ~bus.b : bus.b;
         acc   <= '0;
      end else if (state == RUN) begin
         cnt <= last ? '0 : cnt + CW'(1);
         if (arith) carry <= dsum[DIGIT];
         opa <= opa >> DIGIT;
         opb <= opb >> DIGIT;
         acc <= acc_nxt;
         if (last) begin
            result_q   <= res_fin;
            carryout_q <= (is_add | is_sub) & dsum[DIGIT];
            overflow_q <= (is_add | is_sub) & dov;
            zero_q     <= (res_fin == '0);
            cmd_err_q  <= ~valid;
         end
      end
   end

   assign bus.result   = result_q;
   assign bus.carryout = carryout_q;
   assign bus.overflow = overflow_q;
   assign bus.zero     = zero_q;
   assign bus.cmd_err  = cmd_err_q;
endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: DIGIT=4 tracked every cycle by a reference model, DIGIT=1 and DIGIT=32 spot-checked.
module tb_alu_serial;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic chk_en = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   logic        st[3];
   logic [31:0] ca[3], cb[3];
   logic [7:0]  cc[3];
   logic        bsy[3], dn[3], co[3], ov[3], zr[3], er[3];
   logic [31:0] res[3];

   alu_serial_if #(.WIDTH(32)) if0 ();
   alu_serial_if #(.WIDTH(32)) if1 ();
   alu_serial_if #(.WIDTH(32)) if2 ();

   alu_serial #(.WIDTH(32), .DIGIT(4))  u_d4  (.clk(clk), .reset(reset), .bus(if0));
   alu_serial #(.WIDTH(32), .DIGIT(1))  u_d1  (.clk(clk), .reset(reset), .bus(if1));
   alu_serial #(.WIDTH(32), .DIGIT(32)) u_d32 (.clk(clk), .reset(reset), .bus(if2));

   assign if0.start = st[0]; assign if0.a = ca[0]; assign if0.b = cb[0]; assign if0.command = cc[0];
   assign if1.start = st[1]; assign if1.a = ca[1]; assign if1.b = cb[1]; assign if1.command = cc[1];
   assign if2.start = st[2]; assign if2.a = ca[2]; assign if2.b = cb[2]; assign if2.command = cc[2];
   assign bsy[0] = if0.busy; assign dn[0] = if0.done; assign res[0] = if0.result;
   assign co[0] = if0.carryout; assign ov[0] = if0.overflow; assign zr[0] = if0.zero; assign er[0] = if0.cmd_err;
   assign bsy[1] = if1.busy; assign dn[1] = if1.done; assign res[1] = if1.result;
   assign co[1] = if1.carryout; assign ov[1] = if1.overflow; assign zr[1] = if1.zero; assign er[1] = if1.cmd_err;
   assign bsy[2] = if2.busy; assign dn[2] = if2.done; assign res[2] = if2.result;
   assign co[2] = if2.carryout; assign ov[2] = if2.overflow; assign zr[2] = if2.zero; assign er[2] = if2.cmd_err;

   typedef struct packed {
      logic [31:0] r;
      logic        co;
      logic        ov;
      logic        z;
      logic        err;
   } exp_t;

   // Whole-word reference arithmetic; SLT is a plain signed compare.
   function automatic exp_t alu_ref(input logic [7:0] c, input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      logic [32:0] s;
      e.r = 32'd0; e.co = 1'b0; e.ov = 1'b0; e.z = 1'b0; e.err = 1'b0;
      case (c)
         8'h01: begin
            s = {1'b0, x} + {1'b0, y};
            e.r = s[31:0]; e.co = s[32];
            e.ov = (x[31] == y[31]) && (e.r[31] != x[31]);
         end
         8'h02: begin
            s = {1'b0, x} + {1'b0, ~y} + 33'd1;
            e.r = s[31:0]; e.co = s[32];
            e.ov = (x[31] != y[31]) && (e.r[31] != x[31]);
         end
         8'h04: e.r = x ^ y;
         8'h08: e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         8'h10: e.r = x & y;
         8'h20: e.r = ~(x & y);
         8'h40: e.r = ~(x | y);
         8'h80: e.r = x | y;
         default: e.err = 1'b1;
      endcase
      e.z = (e.r == 32'd0);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle-level model of the DIGIT=4 instance: phase 0 idle, 1 running, 2 done.
   int          m_phase = 0;
   int          m_left = 0;
   logic [31:0] m_a, m_b;
   logic [7:0]  m_c;
   exp_t        m_out;

   always @(posedge clk) begin
      if (reset) begin
         m_phase = 0; m_left = 0;
         m_out.r = 32'd0; m_out.co = 1'b0; m_out.ov = 1'b0; m_out.z = 1'b1; m_out.err = 1'b0;
      end else if (m_phase == 1) begin
         m_left--;
         if (m_left == 0) begin
            m_phase = 2;
            m_out   = alu_ref(m_c, m_a, m_b);
         end
      end else if (st[0]) begin
         m_a = ca[0]; m_b = cb[0]; m_c = cc[0];
         m_phase = 1; m_left = 8;
      end else begin
         m_phase = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_busy", 32'(bsy[0]), 32'(m_phase == 1));
         chk("m_done", 32'(dn[0]), 32'(m_phase == 2));
         chk("m_result", res[0], m_out.r);
         chk("m_carryout", 32'(co[0]), 32'(m_out.co));
         chk("m_overflow", 32'(ov[0]), 32'(m_out.ov));
         chk("m_zero", 32'(zr[0]), 32'(m_out.z));
         chk("m_cmd_err", 32'(er[0]), 32'(m_out.err));
      end
   end

   task automatic wait_done(input int d, output int cyc);
      cyc = 0;
      while (!dn[d] && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_op(input int d, input string nm, input logic [7:0] c,
                         input logic [31:0] x, input logic [31:0] y, input int lat,
                         input logic [31:0] er_, input logic eco, input logic eov,
                         input logic ez, input logic eerr);
      int cyc;
      @(negedge clk);
      ca[d] = x; cb[d] = y; cc[d] = c; st[d] = 1'b1;
      @(negedge clk);
      st[d] = 1'b0;
      wait_done(d, cyc);
      chk({nm, "_latency"}, 32'(cyc), 32'(lat));
      chk({nm, "_result"}, res[d], er_);
      chk({nm, "_carryout"}, 32'(co[d]), 32'(eco));
      chk({nm, "_overflow"}, 32'(ov[d]), 32'(eov));
      chk({nm, "_zero"}, 32'(zr[d]), 32'(ez));
      chk({nm, "_cmd_err"}, 32'(er[d]), 32'(eerr));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      int gap;
      for (int i = 0; i < 3; i++) begin
         st[i] = 1'b0; ca[i] = '0; cb[i] = '0; cc[i] = '0;
      end
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      reset  = 1'b0;
      chk("rst_busy", 32'(bsy[0]), 32'd0);
      chk("rst_done", 32'(dn[0]), 32'd0);
      chk("rst_result", res[0], 32'd0);
      chk("rst_zero", 32'(zr[0]), 32'd1);
      chk("rst_cmd_err", 32'(er[0]), 32'd0);

      run_op(0, "add_wrap",  8'h01, 32'hFFFFFFFF, 32'h00000001, 8, 32'h00000000, 1, 0, 1, 0);
      run_op(0, "add_ovf",   8'h01, 32'h7FFFFFFF, 32'h00000001, 8, 32'h80000000, 0, 1, 0, 0);
      run_op(0, "sub_ovf",   8'h02, 32'h80000000, 32'h00000001, 8, 32'h7FFFFFFF, 1, 1, 0, 0);
      run_op(0, "sub_borrow",8'h02, 32'h00000003, 32'h00000005, 8, 32'hFFFFFFFE, 0, 0, 0, 0);
      run_op(0, "slt_neg",   8'h08, 32'hFFFFFFFB, 32'h00000003, 8, 32'h00000001, 0, 0, 0, 0);
      run_op(0, "slt_ovf",   8'h08, 32'h7FFFFFFF, 32'h80000000, 8, 32'h00000000, 0, 0, 1, 0);
      run_op(0, "xor",       8'h04, 32'hF0F0F0F0, 32'hFF00FF00, 8, 32'h0FF00FF0, 0, 0, 0, 0);
      run_op(0, "and",       8'h10, 32'hF0F0F0F0, 32'hFF00FF00, 8, 32'hF000F000, 0, 0, 0, 0);
      run_op(0, "nand",      8'h20, 32'hF0F0F0F0, 32'hFF00FF00, 8, 32'h0FFF0FFF, 0, 0, 0, 0);
      run_op(0, "nor",       8'h40, 32'hF0F0F0F0, 32'hFF00FF00, 8, 32'h000F000F, 0, 0, 0, 0);
      run_op(0, "or",        8'h80, 32'hF0F0F0F0, 32'hFF00FF00, 8, 32'hFFF0FFF0, 0, 0, 0, 0);
      run_op(0, "bad_cmd",   8'h03, 32'h12345678, 32'h11111111, 8, 32'h00000000, 0, 0, 1, 1);
      run_op(0, "zero_cmd",  8'h00, 32'h12345678, 32'h11111111, 8, 32'h00000000, 0, 0, 1, 1);

      // start pulsed mid-RUN must not disturb the running op
      @(negedge clk);
      ca[0] = 32'd1; cb[0] = 32'd2; cc[0] = 8'h01; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (3) @(negedge clk);
      ca[0] = 32'd5; cb[0] = 32'd9; cc[0] = 8'h02; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      wait_done(0, cyc);
      chk("midrun_latency", 32'(cyc + 4), 32'd8);
      chk("midrun_result", res[0], 32'd3);
      repeat (3) @(negedge clk);
      chk("midrun_no_restart", 32'(bsy[0]), 32'd0);

      // start held across DONE chains a second op
      @(negedge clk);
      ca[0] = 32'd1; cb[0] = 32'd1; cc[0] = 8'h01; st[0] = 1'b1;
      wait_done(0, cyc);
      chk("held_first_latency", 32'(cyc), 32'd9);
      chk("held_first_result", res[0], 32'd2);
      ca[0] = 32'd10; cb[0] = 32'd3; cc[0] = 8'h02;
      @(negedge clk);
      st[0] = 1'b0;
      chk("held_busy_again", 32'(bsy[0]), 32'd1);
      wait_done(0, gap);
      chk("held_done_spacing", 32'(gap + 1), 32'd9);
      chk("held_second_result", res[0], 32'd7);

      // reset in RUN discards the op
      @(negedge clk);
      ca[0] = 32'h12345678; cb[0] = 32'd1; cc[0] = 8'h01; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_reset_busy", 32'(bsy[0]), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("reset_busy", 32'(bsy[0]), 32'd0);
      chk("reset_result", res[0], 32'd0);
      chk("reset_zero", 32'(zr[0]), 32'd1);
      gap = 0;
      repeat (12) begin
         @(negedge clk);
         if (dn[0]) gap++;
      end
      chk("reset_no_done", 32'(gap), 32'd0);

      run_op(1, "d1_add", 8'h01, 32'hFFFFFFFF, 32'h00000001, 32, 32'h00000000, 1, 0, 1, 0);
      run_op(1, "d1_sub", 8'h02, 32'h80000000, 32'h00000001, 32, 32'h7FFFFFFF, 1, 1, 0, 0);
      run_op(2, "d32_add", 8'h01, 32'hFFFFFFFF, 32'h00000001, 1, 32'h00000000, 1, 0, 1, 0);
      run_op(2, "d32_sub", 8'h02, 32'h80000000, 32'h00000001, 1, 32'h7FFFFFFF, 1, 1, 0, 0);
      run_op(2, "d32_slt", 8'h08, 32'h7FFFFFFF, 32'h80000000, 1, 32'h00000000, 0, 0, 1, 0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_serial.md
# alu_serial

Parametrised multi-cycle ALU that builds on our one-bit ALU slice: it executes the same eight one-hot operations on WIDTH-bit operands, DIGIT bits per clock, LSB digit first. A carry register links successive digits. It sits beside the register file as the datapath's arithmetic/logic unit, with a start/busy/done handshake to the control FSM, and trades latency for area against a fully unrolled WIDTH-slice ALU.

## Interface
- WIDTH, default 32: operand/result width in bits.
- DIGIT, default 4: bits processed per cycle.
  - WIDTH % DIGIT must be 0; N = WIDTH/DIGIT.
  - DIGIT = WIDTH gives a single-cycle datapath.
- clk, input, 1: clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset; one clock, reset is synchronous and active-high.
- start, input, 1: request; sampled only in IDLE or DONE.
- a, input, WIDTH: operand A; captured on the accepting edge.
- b, input, WIDTH: operand B; captured on the accepting edge.
- command, input, 8: one-hot opcode; captured on the accepting edge.
  - bit 0 ADD, bit 1 SUB, bit 2 XOR, bit 3 SLT.
  - bit 4 AND, bit 5 NAND, bit 6 NOR, bit 7 OR.
- busy, output, 1: operation in progress (RUN).
- done, output, 1: one-cycle pulse; result and flags are valid from this cycle on.
- result, output, WIDTH: registered result; held until the next completion.
- carryout, output, 1: carry out of the MSB for ADD/SUB; 0 otherwise.
- overflow, output, 1: signed overflow for ADD/SUB; 0 otherwise.
- zero, output, 1: 1 iff result == 0 (all ops).
- cmd_err, output, 1: command was not exactly one-hot.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: start=1 captures a, b and command, clears the digit counter, moves to RUN.
  - RUN: each edge processes digit k (bits k·DIGIT .. k·DIGIT+DIGIT-1) and increments k. The edge processing digit N-1 moves to DONE.
  - DONE: done=1 for exactly one cycle.
    - start=1 in DONE is accepted and goes to RUN (back-to-back operation).
    - Otherwise the block returns to IDLE.
- Carry register initialisation at capture: 0 for ADD; 1 for SUB and SLT. SUB is A + ~B + 1.
- Per-digit operation:
  - ADD/SUB/SLT: DIGIT-bit ripple add; carry register updated with the digit carry-out.
  - XOR/AND/NAND/NOR/OR: bitwise; the carry register is unused.
- Internal accumulator collects the digits. result and the flags update only on the edge entering DONE; they are stable throughout RUN.
- Flags:
  - carryout: final carry. For SUB, carryout=1 means no borrow (A ≥ B unsigned).
  - overflow: carry into MSB XOR carry out of MSB.
  - SLT result: {WIDTH-1 zeros, sign(A−B) XOR overflow}. carryout and overflow are forced to 0 for SLT.
  - zero: computed from the final result.
- Invalid command (zero or more than one bit set):
  - Runs the full N cycles with the same timing.
  - Completes with result=0, zero=1, carryout=0, overflow=0, cmd_err=1.
  - cmd_err is 0 for valid commands and updates with the other flags.
- start while in RUN is ignored; operands and command are not re-captured.

## Timing
- Reset values: state IDLE, busy=0, done=0, result=0, carryout=0, overflow=0, zero=1, cmd_err=0, carry register 0, counter 0.
- Latency: start sampled at edge E → busy=1 after E through E+N−1, done=1 after edge E+N.
  - Default WIDTH=32, DIGIT=4 gives N=8.
- Throughput: one operation every N+1 cycles if start is held high or pulsed in DONE.
- busy and done are never both 1.
- Reset asserted in any state, including mid-RUN, wins over start:
  - On the next edge all registers take their reset values.
  - The partial result is discarded and no done pulse occurs.
- Counter wraps only through the RUN→DONE transition; it never exceeds N−1.

## Test plan
- ADD a=0xFFFFFFFF, b=0x00000001 → done 8 cycles after start; result=0x00000000, carryout=1, overflow=0, zero=1.
- SUB a=0x80000000, b=0x00000001 → result=0x7FFFFFFF, carryout=1, overflow=1, zero=0.
- SLT a=0xFFFFFFFB, b=0x00000003 → result=0x00000001.
  - a=0x7FFFFFFF, b=0x80000000 → result=0x00000000 (overflow case).
- Logic ops with a=0xF0F0F0F0, b=0xFF00FF00; carryout=overflow=0 in all cases:
  - XOR → 0x0FF00FF0; AND → 0xF000F000; NAND → 0x0FFF0FFF.
  - NOR → 0x000F000F; OR → 0xFFF0FFF0.
- Handshake:
  - start pulsed mid-RUN → ignored, first result unaffected.
  - start held through DONE → second op starts immediately, done 9 cycles apart.
  - reset at RUN cycle 3 → busy=0, result=0, zero=1 next cycle, no done pulse.
- command=0x03 → cmd_err=1, result=0, zero=1.
- Repeat the ADD/SUB vectors with DIGIT=1 (done 32 cycles after start) and DIGIT=32 (done 1 cycle after start).
